booth_mult: RTL

BOOTH_MULT -- requirements
Module: booth_mult

---
 rtl/mult_pkg.sv | 22 ++
 rtl/booth_step.sv | 58 +++++
 rtl/booth_mult.sv | 109 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the Booth multiplier.
// BOOTH_MULT_RADIX4_EN selects radix-4 modified-Booth steps (16 iterations)
// instead of radix-2 steps (32 iterations).
package mult_pkg;

  localparam int unsigned OP_W    = 32;
  localparam int unsigned ITER_R2 = 32;
  localparam int unsigned ITER_R4 = 16;

`ifdef BOOTH_MULT_RADIX4_EN
  localparam int unsigned ITER = ITER_R4;
`else
  localparam int unsigned ITER = ITER_R2;
`endif

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/subtract the multiplicand per the
// recoded digit, then arithmetic right shift of {acc, q, q_m1}.
// BOOTH_MULT_RADIX4_EN selects a radix-4 step (2-bit shift) over radix-2.
module booth_step
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] acc_i,
  input  logic [OP_W-1:0] q_i,
  input  logic            q_m1_i,
  input  logic [OP_W-1:0] m_i,
  output logic [OP_W-1:0] acc_o,
  output logic [OP_W-1:0] q_o,
  output logic            q_m1_o
);

`ifdef BOOTH_MULT_RADIX4_EN
  // Two guard bits so that +/-2M of the most negative operand stays exact.
  logic [OP_W+1:0] m_ext;
  logic [OP_W+1:0] m2_ext;
  logic [OP_W+1:0] sum;

  // Radix-4 digit select from (Q1, Q0, Q-1), then 2-bit arithmetic shift.
  always_comb begin
    m_ext  = {{2{m_i[OP_W-1]}}, m_i};
    m2_ext = m_ext << 1;
    sum    = {{2{acc_i[OP_W-1]}}, acc_i};
    case ({q_i[1:0], q_m1_i})
      3'b001, 3'b010: sum = sum + m_ext;
      3'b011:         sum = sum + m2_ext;
      3'b100:         sum = sum - m2_ext;
      3'b101, 3'b110: sum = sum - m_ext;
      default:        ;
    endcase
    acc_o  = sum[OP_W+1:2];
    q_o    = {sum[1:0], q_i[OP_W-1:2]};
    q_m1_o = q_i[1];
  end
`else
  // One guard bit so that negating 0x80000000 does not overflow.
  logic [OP_W:0] m_ext;
  logic [OP_W:0] sum;

  // Radix-2 pair select from (Q0, Q-1), then 1-bit arithmetic shift.
  always_comb begin
    m_ext = {m_i[OP_W-1], m_i};
    sum   = {acc_i[OP_W-1], acc_i};
    case ({q_i[0], q_m1_i})
      2'b01:   sum = sum + m_ext;
      2'b10:   sum = sum - m_ext;
      default: ;
    endcase
    acc_o  = sum[OP_W:1];
    q_o    = {sum[0], q_i[OP_W-1:1]};
    q_m1_o = q_i[0];
  end
`endif

endmodule

// File: rtl/booth_mult.sv
// Sequential signed 32x32 Booth multiplier with IDLE/RUN/DONE control.
// BOOTH_MULT_RADIX4_EN switches the datapath to radix-4 (16 steps).
module booth_mult
  import mult_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] hi,
  output logic [OP_W-1:0] lo,
  output logic            done,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(ITER);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]   q_q, q_d;
  logic              q_m1_q, q_m1_d;
  logic [OP_W-1:0]   m_q, m_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   hi_q, hi_d;
  logic [OP_W-1:0]   lo_q, lo_d;

  logic [OP_W-1:0]   step_acc;
  logic [OP_W-1:0]   step_q;
  logic              step_q_m1;

  booth_step u_step (
    .acc_i  (acc_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .m_i    (m_q),
    .acc_o  (step_acc),
    .q_o    (step_q),
    .q_m1_o (step_q_m1)
  );

  // Control FSM and datapath next-state; hi/lo only change on the last step.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q_m1_d  = q_m1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          q_m1_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = step_acc;
        q_d    = step_q;
        q_m1_d = step_q_m1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          hi_d    = step_acc;
          lo_d    = step_q;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q_m1_q  <= q_m1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = (state_q == DONE);
  assign busy = (state_q == RUN);

endmodule
